// File: rtl/digit_step_sequencer_if.sv
// Signal bundle between the digit source stage and whatever drives/observes it.
// Optional macro DIGIT_SEQ_BLANK_EN adds the blank request line.
// There is no valid/ready handshake here: run, up and load_val are levels, step
// is a raw asynchronous pushbutton, and load is a single-cycle strobe that is
// always accepted on the edge where it is sampled.
interface digit_step_sequencer_if;
    logic       run;
    logic       step;
    logic       up;
    logic       load;
    logic [3:0] load_val;
`ifdef DIGIT_SEQ_BLANK_EN
    logic       blank;
`endif
    logic [3:0] digit;
    logic       W;
    logic       X;
    logic       Y;
    logic       Z;
    logic       tc;

    // Stimulus side: drives the controls, observes the digit and its code.
    modport master (
`ifdef DIGIT_SEQ_BLANK_EN
        output blank,
`endif
        output run, step, up, load, load_val,
        input  digit, W, X, Y, Z, tc
    );

    // Sequencer side.
    modport slave (
`ifdef DIGIT_SEQ_BLANK_EN
        input  blank,
`endif
        input  run, step, up, load, load_val,
        output digit, W, X, Y, Z, tc
    );
endinterface

// File: rtl/digit_step_sequencer.sv
// Decimal digit source for the 7-segment decoder stage.
// The digit (0-9) advances on a synchronized pushbutton edge or a prescaled
// auto-run tick, or takes a clamped parallel load. It is presented both as
// binary and as the decoder's weighted WXYZ code (X + 2Y + 2W + 6Z).
// Optional macro DIGIT_SEQ_BLANK_EN: adds bus.blank, which forces WXYZ=1011
// (decoder blank) while the digit keeps counting.
module digit_step_sequencer #(
    parameter int PRESCALE = 25_000_000
) (
    input logic                   clk,
    input logic                   reset,
    digit_step_sequencer_if.slave bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESCALE_LAST = PW'(PRESCALE - 1);

    logic          s1, s2, s3;
    logic          step_evt;
    logic [PW-1:0] prescaler;
    logic          tick;
    logic [3:0]    digit_q;
    logic [3:0]    code_q;
    logic          tc_q;
    logic [3:0]    next_digit;
    logic          next_wrap;

    // Weighted decoder code {W,X,Y,Z} for a binary digit.
    function automatic logic [3:0] encode(input logic [3:0] d);
        case (d)
            4'd0:    encode = 4'b0000;
            4'd1:    encode = 4'b0100;
            4'd2:    encode = 4'b0010;
            4'd3:    encode = 4'b0110;
            4'd4:    encode = 4'b1010;
            4'd5:    encode = 4'b1110;
            4'd6:    encode = 4'b0001;
            4'd7:    encode = 4'b0101;
            4'd8:    encode = 4'b0011;
            4'd9:    encode = 4'b0111;
            default: encode = 4'b1011;
        endcase
    endfunction

    // Two-flop synchronizer plus a third flop for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.step;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign step_evt = s2 & ~s3;

    // Auto-run prescaler: free-runs 0..PRESCALE-1 while run is high, parked at 0 otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
        end else if (!bus.run) begin
            prescaler <= '0;
        end else if (prescaler == PRESCALE_LAST) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    assign tick = bus.run && (prescaler == PRESCALE_LAST);

    // Next digit: load beats advance; a coincident step_evt and tick give one step only.
    always_comb begin
        next_digit = digit_q;
        next_wrap  = 1'b0;
        if (bus.load) begin
            next_digit = (bus.load_val > 4'd9) ? 4'd9 : bus.load_val;
        end else if (step_evt || tick) begin
            if (bus.up) begin
                if (digit_q == 4'd9) begin
                    next_digit = 4'd0;
                    next_wrap  = 1'b1;
                end else begin
                    next_digit = digit_q + 4'd1;
                end
            end else begin
                if (digit_q == 4'd0) begin
                    next_digit = 4'd9;
                    next_wrap  = 1'b1;
                end else begin
                    next_digit = digit_q - 4'd1;
                end
            end
        end
    end

    // Register digit, its code and the wrap pulse together so they never disagree.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_q <= 4'd0;
            code_q  <= 4'b0000;
            tc_q    <= 1'b0;
        end else begin
            digit_q <= next_digit;
            tc_q    <= next_wrap;
`ifdef DIGIT_SEQ_BLANK_EN
            code_q  <= bus.blank ? 4'b1011 : encode(next_digit);
`else
            code_q  <= encode(next_digit);
`endif
        end
    end

    assign bus.digit = digit_q;
    assign bus.W     = code_q[3];
    assign bus.X     = code_q[2];
    assign bus.Y     = code_q[1];
    assign bus.Z     = code_q[0];
    assign bus.tc    = tc_q;
endmodule

// File: tb/tb_digit_step_sequencer.sv
// Testbench for digit_step_sequencer: a vector table of step/load operations
// with hand-computed digit/code/tc values, plus hand-written sequences for
// auto-run timing, coincident events, held step and asynchronous reset.
module tb_digit_step_sequencer;
    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    digit_step_sequencer_if bus ();

    digit_step_sequencer #(.PRESCALE(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       up;
        logic       is_load;
        logic [3:0] load_val;
        logic [3:0] exp_digit;
        logic [3:0] exp_wxyz;
        logic       exp_tc;
    } vec_t;

    vec_t vecs [20];

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] wxyz();
        return {bus.W, bus.X, bus.Y, bus.Z};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Raises step and returns at the negedge right after the edge that applies the advance.
    task automatic pulse_step();
        bus.step = 1'b1;
        repeat (3) @(negedge clk);
        bus.step = 1'b0;
    endtask

    task automatic do_load(input logic [3:0] v);
        bus.load     = 1'b1;
        bus.load_val = v;
        @(negedge clk);
        bus.load     = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        vecs[0]  = '{1'b1, 1'b0, 4'd0,  4'd1, 4'b0100, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 4'd0,  4'd2, 4'b0010, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 4'd0,  4'd3, 4'b0110, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 4'd0,  4'd4, 4'b1010, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 4'd0,  4'd5, 4'b1110, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 4'd0,  4'd6, 4'b0001, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 4'd0,  4'd7, 4'b0101, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 4'd0,  4'd8, 4'b0011, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 4'd0,  4'd9, 4'b0111, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 4'd0,  4'd0, 4'b0000, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 4'd0,  4'd9, 4'b0111, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 4'd0,  4'd8, 4'b0011, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 4'd13, 4'd9, 4'b0111, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 4'd4,  4'd4, 4'b1010, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 4'd0,  4'd5, 4'b1110, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 4'd0,  4'd0, 4'b0000, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 4'd0,  4'd9, 4'b0111, 1'b1};
        vecs[17] = '{1'b1, 1'b1, 4'd15, 4'd9, 4'b0111, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 4'd0,  4'd0, 4'b0000, 1'b1};
        vecs[19] = '{1'b0, 1'b1, 4'd10, 4'd9, 4'b0111, 1'b0};

        reset        = 1'b1;
        bus.run      = 1'b0;
        bus.step     = 1'b0;
        bus.up       = 1'b1;
        bus.load     = 1'b0;
        bus.load_val = 4'd0;
`ifdef DIGIT_SEQ_BLANK_EN
        bus.blank    = 1'b0;
`endif
        idle(2);
        reset = 1'b0;
        idle(2);
        check("reset digit", 8'(bus.digit), 8'd0);
        check("reset wxyz", 8'(wxyz()), 8'h0);
        check("reset tc", 8'(bus.tc), 8'd0);

        // table of single operations
        for (int i = 0; i < 20; i++) begin
            bus.up = vecs[i].up;
            if (vecs[i].is_load) do_load(vecs[i].load_val);
            else pulse_step();
            check($sformatf("vec%0d digit", i), 8'(bus.digit), 8'(vecs[i].exp_digit));
            check($sformatf("vec%0d wxyz", i), 8'(wxyz()), 8'(vecs[i].exp_wxyz));
            check($sformatf("vec%0d tc", i), 8'(bus.tc), 8'(vecs[i].exp_tc));
            idle(2);
            check($sformatf("vec%0d tc_after", i), 8'(bus.tc), 8'd0);
        end

        // auto-run: PRESCALE=4, 20 cycles from 0 -> 5
        bus.up = 1'b1;
        do_load(4'd0);
        bus.run = 1'b1;
        idle(3);
        check("run before first tick", 8'(bus.digit), 8'd0);
        idle(1);
        check("run first tick", 8'(bus.digit), 8'd1);
        idle(16);
        check("run 20 cycles digit", 8'(bus.digit), 8'd5);
        check("run 20 cycles wxyz", 8'(wxyz()), 8'b1110);
        bus.run = 1'b0;
        idle(3);
        check("run stopped", 8'(bus.digit), 8'd5);

        // step_evt and tick on the same edge: 3 -> 4, not 5
        do_load(4'd3);
        bus.run = 1'b1;
        idle(1);
        bus.step = 1'b1;
        idle(2);
        check("coincide before", 8'(bus.digit), 8'd3);
        idle(1);
        check("coincide single step", 8'(bus.digit), 8'd4);
        bus.run = 1'b0;
        idle(3);
        check("coincide settle", 8'(bus.digit), 8'd4);
        bus.step = 1'b0;
        idle(3);

        // step held 50 cycles: one increment only
        bus.step = 1'b1;
        idle(50);
        check("held step", 8'(bus.digit), 8'd5);
        bus.step = 1'b0;
        idle(3);
        check("held step release", 8'(bus.digit), 8'd5);

        // load beats a same-cycle step_evt
        bus.step = 1'b1;
        idle(2);
        bus.load     = 1'b1;
        bus.load_val = 4'd13;
        idle(1);
        bus.load = 1'b0;
        check("load over step", 8'(bus.digit), 8'd9);
        idle(1);
        check("load over step after", 8'(bus.digit), 8'd9);
        bus.step = 1'b0;
        idle(3);

        // asynchronous reset between edges at digit 7
        do_load(4'd7);
        #2 reset = 1'b1;
        #1;
        check("async reset digit", 8'(bus.digit), 8'd0);
        check("async reset wxyz", 8'(wxyz()), 8'h0);
        @(negedge clk);
        reset = 1'b0;
        idle(1);

        // asynchronous reset while tc is high
        bus.up = 1'b0;
        pulse_step();
        check("down wrap tc", 8'(bus.tc), 8'd1);
        #2 reset = 1'b1;
        #1;
        check("async reset tc", 8'(bus.tc), 8'd0);
        check("async reset digit2", 8'(bus.digit), 8'd0);
        bus.up   = 1'b1;
        bus.step = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idle(5);
        check("step high at reset release", 8'(bus.digit), 8'd1);
        bus.step = 1'b0;
        idle(3);

`ifdef DIGIT_SEQ_BLANK_EN
        bus.blank = 1'b1;
        do_load(4'd2);
        check("blank digit", 8'(bus.digit), 8'd2);
        check("blank wxyz", 8'(wxyz()), 8'b1011);
        pulse_step();
        check("blank count digit", 8'(bus.digit), 8'd3);
        check("blank count wxyz", 8'(wxyz()), 8'b1011);
        bus.blank = 1'b0;
        idle(1);
        check("unblank wxyz", 8'(wxyz()), 8'b0110);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
